// File: rtl/clint_timer.sv
// Machine timer / software-interrupt unit: 64-bit mtime/mtimecmp, msip and an
// mtime high-word snapshot on a single-cycle request/ready register bus.
module clint_timer #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        bus_err,
  output logic        timer_irq,
  output logic        soft_irq,
  output logic [63:0] mtime_o
);

  localparam int unsigned PRESC_W = 16;
  localparam logic [PRESC_W-1:0] DIV_LAST = PRESC_W'(CLK_DIV - 1);

  localparam logic [4:0] A_MTIME_LO = 5'h00;
  localparam logic [4:0] A_MTIME_HI = 5'h04;
  localparam logic [4:0] A_CMP_LO   = 5'h08;
  localparam logic [4:0] A_CMP_HI   = 5'h0C;
  localparam logic [4:0] A_MSIP     = 5'h10;
  localparam logic [4:0] A_SNAP_HI  = 5'h14;
  localparam logic [4:0] A_END      = 5'h18;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        mtimecmp_q, mtimecmp_d;
  logic               msip_q, msip_d;
  logic [31:0]        snap_hi_q, snap_hi_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic               timer_irq_q, timer_irq_d;

  logic        tick_c;
  logic        addr_bad_c;
  logic        err_c;
  logic        rd_ok_c;
  logic        wr_ok_c;
  logic [31:0] rd_sel_c;

  // Address decode: out-of-range, misaligned, or a write to the read-only snapshot.
  always_comb begin
    tick_c     = (presc_q == DIV_LAST);
    addr_bad_c = (bus_addr >= A_END) || (bus_addr[1:0] != 2'b00);
    err_c      = bus_req && (addr_bad_c || (bus_we && (bus_addr == A_SNAP_HI)));
    rd_ok_c    = bus_req && !bus_we && !addr_bad_c;
    wr_ok_c    = bus_req && bus_we && !err_c;
  end

  always_comb begin
    rd_sel_c = 32'h0;
    case (bus_addr)
      A_MTIME_LO: rd_sel_c = mtime_q[31:0];
      A_MTIME_HI: rd_sel_c = mtime_q[63:32];
      A_CMP_LO:   rd_sel_c = mtimecmp_q[31:0];
      A_CMP_HI:   rd_sel_c = mtimecmp_q[63:32];
      A_MSIP:     rd_sel_c = {31'h0, msip_q};
      A_SNAP_HI:  rd_sel_c = snap_hi_q;
      default:    rd_sel_c = 32'h0;
    endcase
  end

  // Next-state: an mtime write suppresses that cycle's increment for both halves.
  always_comb begin
    presc_d     = tick_c ? '0 : presc_q + PRESC_W'(1);
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    snap_hi_d   = snap_hi_q;
    rdata_d     = 32'h0;
    ready_d     = bus_req;
    err_d       = err_c;
    timer_irq_d = (mtime_q >= mtimecmp_q);

    if (wr_ok_c && (bus_addr == A_MTIME_LO)) begin
      mtime_d[31:0] = bus_wdata;
    end else if (wr_ok_c && (bus_addr == A_MTIME_HI)) begin
      mtime_d[63:32] = bus_wdata;
    end else if (tick_c) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr_ok_c && (bus_addr == A_CMP_LO)) mtimecmp_d[31:0]  = bus_wdata;
    if (wr_ok_c && (bus_addr == A_CMP_HI)) mtimecmp_d[63:32] = bus_wdata;
    if (wr_ok_c && (bus_addr == A_MSIP))   msip_d            = bus_wdata[0];

    if (rd_ok_c) begin
      rdata_d = rd_sel_c;
      if (bus_addr == A_MTIME_LO) snap_hi_d = mtime_q[63:32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      mtime_q     <= 64'h0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      snap_hi_q   <= 32'h0;
      rdata_q     <= 32'h0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      timer_irq_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      snap_hi_q   <= snap_hi_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      timer_irq_q <= timer_irq_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign bus_ready = ready_q;
  assign bus_err   = err_q;
  assign timer_irq = timer_irq_q;
  assign soft_irq  = msip_q;
  assign mtime_o   = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: a CLK_DIV=1 and a CLK_DIV=4 instance share one bus;
// read/error responses are scoreboarded, timing corners are checked by hand.
module tb_clint_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_req;
  logic        bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;

  logic [31:0] rdata1, rdata4;
  logic        ready1, ready4, err1, err4, tirq1, tirq4, sirq1, sirq4;
  logic [63:0] mtime1, mtime4;

  always #5 clk = ~clk;

  clint_timer #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata1),
    .bus_ready(ready1), .bus_err(err1), .timer_irq(tirq1),
    .soft_irq(sirq1), .mtime_o(mtime1)
  );

  clint_timer #(.CLK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata4),
    .bus_ready(ready4), .bus_err(err4), .timer_irq(tirq4),
    .soft_irq(sirq4), .mtime_o(mtime4)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_soft;
  } vec_t;

  resp_t sb_q[$];
  vec_t  vecs[18];
  int    checks   = 0;
  int    failures = 0;
  logic  exp_rdy;
  int    cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for a single cycle; its expected response goes to the scoreboard.
  task automatic issue(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                       input logic [31:0] er, input logic ee);
    resp_t r;
    r.rdata = er;
    r.err   = ee;
    sb_q.push_back(r);
    bus_req   = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    @(posedge clk);
    #1;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 5'h0;
    bus_wdata = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready1"}, 64'(ready1), 64'd0);
    check({tag, "_err1"},   64'(err1),   64'd0);
    check({tag, "_rdata1"}, 64'(rdata1), 64'd0);
    check({tag, "_tirq1"},  64'(tirq1),  64'd0);
    check({tag, "_sirq1"},  64'(sirq1),  64'd0);
    check({tag, "_mtime1"}, mtime1,      64'd0);
    check({tag, "_ready4"}, 64'(ready4), 64'd0);
    check({tag, "_err4"},   64'(err4),   64'd0);
    check({tag, "_rdata4"}, 64'(rdata4), 64'd0);
    check({tag, "_tirq4"},  64'(tirq4),  64'd0);
    check({tag, "_sirq4"},  64'(sirq4),  64'd0);
    check({tag, "_mtime4"}, mtime4,      64'd0);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_rdy <= 1'b0;
      cyc     <= 0;
    end else begin
      exp_rdy <= bus_req;
      cyc     <= cyc + 1;
    end
  end

  // Response monitor: ready exactly one cycle after each request, data from the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      check("ready_timing", 64'(ready1), 64'(exp_rdy));
      check("ready4_timing", 64'(ready4), 64'(exp_rdy));
      if (ready1) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready: got ready with no request outstanding");
        end else begin
          resp_t r;
          r = sb_q.pop_front();
          check("resp_rdata", 64'(rdata1), 64'(r.rdata));
          check("resp_err", 64'(err1), 64'(r.err));
        end
      end else begin
        check("idle_rdata", 64'(rdata1), 64'd0);
        check("idle_err", 64'(err1), 64'd0);
      end
    end
  end

  initial begin
    logic found;
    logic [63:0] v;

    vecs[0]  = '{1'b1, 5'h10, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1};
    vecs[1]  = '{1'b0, 5'h10, 32'h0,         32'h1,         1'b0, 1'b1};
    vecs[2]  = '{1'b1, 5'h11, 32'h0,         32'h0,         1'b1, 1'b1};
    vecs[3]  = '{1'b0, 5'h10, 32'h0,         32'h1,         1'b0, 1'b1};
    vecs[4]  = '{1'b1, 5'h10, 32'h0,         32'h0,         1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'h10, 32'h0,         32'h0,         1'b0, 1'b0};
    vecs[6]  = '{1'b1, 5'h08, 32'hA5A5_0000, 32'h0,         1'b0, 1'b0};
    vecs[7]  = '{1'b1, 5'h0C, 32'h0000_1234, 32'h0,         1'b0, 1'b0};
    vecs[8]  = '{1'b0, 5'h08, 32'h0,         32'hA5A5_0000, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 5'h0C, 32'h0,         32'h0000_1234, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'h18, 32'h0,         32'h0,         1'b1, 1'b0};
    vecs[11] = '{1'b1, 5'h1C, 32'h5,         32'h0,         1'b1, 1'b0};
    vecs[12] = '{1'b0, 5'h02, 32'h0,         32'h0,         1'b1, 1'b0};
    vecs[13] = '{1'b1, 5'h09, 32'h0,         32'h0,         1'b1, 1'b0};
    vecs[14] = '{1'b1, 5'h14, 32'hDEAD_BEEF, 32'h0,         1'b1, 1'b0};
    vecs[15] = '{1'b0, 5'h14, 32'h0,         32'h1,         1'b0, 1'b0};
    vecs[16] = '{1'b0, 5'h08, 32'h0,         32'hA5A5_0000, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 5'h1F, 32'h0,         32'h0,         1'b1, 1'b0};

    reset     = 1'b1;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 5'h0;
    bus_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Free-running count from reset, first read sees 10.
    repeat (10) idle();
    issue(1'b0, 5'h00, 32'h0, 32'd10, 1'b0);

    // Low-to-high carry and snapshot coherence.
    issue(1'b1, 5'h00, 32'hFFFF_FFFE, 32'h0, 1'b0);
    issue(1'b1, 5'h04, 32'h0, 32'h0, 1'b0);
    repeat (3) idle();
    check("carry_mtime_o", mtime1, 64'h1_0000_0001);
    issue(1'b0, 5'h00, 32'h0, 32'h1, 1'b0);
    issue(1'b0, 5'h14, 32'h0, 32'h1, 1'b0);

    // Timer interrupt rise one cycle after mtime reaches mtimecmp.
    issue(1'b1, 5'h04, 32'h0, 32'h0, 1'b0);
    issue(1'b1, 5'h00, 32'h0, 32'h0, 1'b0);
    issue(1'b1, 5'h08, 32'd20, 32'h0, 1'b0);
    issue(1'b1, 5'h0C, 32'h0, 32'h0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mtime1 == 64'd20) begin
        found = 1'b1;
        break;
      end
      idle();
    end
    check("timer_wait_mtime20", 64'(found), 64'd1);
    if (found) begin
      check("tirq_at_cmp", 64'(tirq1), 64'd0);
      idle();
      check("tirq_rise", 64'(tirq1), 64'd1);
    end
    issue(1'b1, 5'h0C, 32'hFFFF_FFFF, 32'h0, 1'b0);
    check("tirq_hold_n1", 64'(tirq1), 64'd1);
    idle();
    check("tirq_fall_n2", 64'(tirq1), 64'd0);

    // Prescaler: CLK_DIV=4 ticks on cycles where cyc is a multiple of 4.
    for (int i = 0; i < 8; i++) begin
      if ((cyc % 4) == 0) break;
      idle();
    end
    v = mtime4;
    repeat (3) idle();
    check("presc_hold", mtime4, v);
    idle();
    check("presc_step", mtime4, v + 64'd1);
    repeat (3) idle();
    issue(1'b1, 5'h00, 32'h0000_1234, 32'h0, 1'b0);
    check("wr_wins_div4", 64'(mtime4[31:0]), 64'h1234);
    check("wr_wins_div1", 64'(mtime1[31:0]), 64'h1234);
    repeat (4) idle();
    check("after_wr_tick", 64'(mtime4[31:0]), 64'h1235);

    // msip, mtimecmp access and bus error table.
    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
      check($sformatf("vec%0d_soft", i), 64'(sirq1), 64'(vecs[i].exp_soft));
    end

    // Reset with timer_irq/soft_irq high and a read in flight.
    issue(1'b1, 5'h10, 32'h1, 32'h0, 1'b0);
    issue(1'b1, 5'h0C, 32'h0, 32'h0, 1'b0);
    issue(1'b1, 5'h08, 32'h0, 32'h0, 1'b0);
    idle();
    check("pre_reset_tirq", 64'(tirq1), 64'd1);
    check("pre_reset_sirq", 64'(sirq1), 64'd1);
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = 5'h00;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    bus_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    issue(1'b0, 5'h0C, 32'h0, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 5'h08, 32'h0, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 5'h10, 32'h0, 32'h0, 1'b0);
    idle();
    idle();
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
# clint_timer

Machine-level timer and software-interrupt unit for the single-hart core. It provides memory-mapped 64-bit `mtime`/`mtimecmp` and an `msip` register on a simple 32-bit request/ready bus. It drives the pending-interrupt lines that feed the CSR unit's `mip` timer (bit 7) and software (bit 3) fields. It also exports `mtime` for the `time`/`timeh` read path.

## Interface

Parameters:
- `CLK_DIV`, default 1: `clk` cycles per `mtime` tick; legal range 1..65535.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: asynchronous, active-high.
- `bus_req`, input, 1: access request; may assert on any cycle and is never back-pressured.
- `bus_we`, input, 1: 1 = write, 0 = read; qualified by `bus_req`.
- `bus_addr`, input, 5: byte offset within the block.
- `bus_wdata`, input, 32: write data.
- `bus_rdata`, output, 32: read data; valid while `bus_ready`=1, otherwise 0.
- `bus_ready`, output, 1: one-cycle completion pulse for every request.
- `bus_err`, output, 1: one-cycle error pulse, coincident with `bus_ready`.
- `timer_irq`, output, 1: machine timer interrupt pending, level.
- `soft_irq`, output, 1: machine software interrupt pending, level.
- `mtime_o`, output, 64: current `mtime` register value.

## Operation

Register map (offset: register, access):
- 0x00 `mtime[31:0]`, RW. Reading this offset also loads `snap_hi` with `mtime[63:32]` of the same cycle.
- 0x04 `mtime[63:32]`, RW.
- 0x08 `mtimecmp[31:0]`, RW.
- 0x0C `mtimecmp[63:32]`, RW.
- 0x10 `msip`, RW. Only bit 0 is implemented; bits 31:1 read 0 and ignore writes.
- 0x14 `snap_hi`, RO. Writes to it are ignored and raise `bus_err`.

Bus errors:
- An offset of 0x18 or above, or `bus_addr[1:0]` ≠ 0, is an error.
- On error: read data 0, write ignored, `bus_err`=1.

Reset values:
- `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0, `snap_hi`=0, prescaler=0.
- `bus_ready`=0, `bus_err`=0, `bus_rdata`=0, `timer_irq`=0, `soft_irq`=0.

Prescaler:
- Counter counts 0..CLK_DIV-1 and wraps to 0.
- A tick occurs on a cycle where the counter equals CLK_DIV-1. With CLK_DIV=1, every cycle is a tick.
- The prescaler is never cleared by bus writes.

`mtime`:
- Increments by 1 on each tick, as a full 64-bit add with carry from low to high word.
- 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.

Write vs. increment in the same cycle:
- A bus write to either `mtime` half wins for the whole 64-bit register: the written half takes `bus_wdata`, the other half holds its current value, and no increment happens that cycle. The tick is lost.
- Writes to `mtimecmp`/`msip` do not affect the increment.

Interrupt lines:
- `timer_irq` is registered: it is loaded each cycle with (`mtime` >= `mtimecmp`), an unsigned 64-bit compare of the current register values.
- `soft_irq` is a direct copy of the `msip[0]` flop.
- Both stay asserted until software changes the registers. There is no hardware clear.

## Timing

Bus responses:
- A request in cycle N produces `bus_ready`=1 in cycle N+1. Back-to-back requests give back-to-back pulses.
- Read data is the register value sampled in cycle N, before any update made in cycle N.
- Writes update registers at the end of cycle N, so a read in N+1 sees the new value.

Interrupt latency:
- `timer_irq`: if `mtime` >= `mtimecmp` first holds during cycle N, `timer_irq` rises in N+1.
- `timer_irq` deassert: a write that makes the compare false, issued in N, lowers `timer_irq` in N+2.
- `soft_irq`: a `msip` write issued in N is visible on `soft_irq` in N+1.

Snapshot and export:
- `snap_hi` loads in the same cycle as the 0x00 read. A read of 0x14 in N+1 or later returns the high word consistent with that low-word read.
- `mtime_o` is the register output with zero added latency.

Reset:
- Asserting `reset` at any time, including mid-transaction, clears all state immediately.
- A request whose `bus_ready` would have fallen inside reset produces no response.

## Test plan

- Counting and snapshot: CLK_DIV=1; after reset, run 10 cycles, then read 0x00 -> `bus_rdata`=10 on the ready cycle, and `bus_ready` pulses exactly one cycle after `bus_req`.
- Carry and snapshot: write 0x00=32'hFFFF_FFFE and 0x04=0, wait 3 cycles; read 0x00 then 0x14 -> low word small, `snap_hi`=1, and `mtime_o` carried correctly.
- Timer interrupt: set `mtimecmp`=20 with `mtime` running from 0 -> `timer_irq` rises the cycle after `mtime_o`=20. Then write 0x0C=32'hFFFF_FFFF -> `timer_irq` falls 2 cycles after the request.
- Prescaler and write precedence: CLK_DIV=4 -> `mtime` advances once per 4 cycles. A write to 0x00 on a tick cycle -> `mtime` equals the written value, not value+1.
- Software interrupt and errors: write 0x10=32'hFFFF_FFFF -> reading 0x10 returns 1 and `soft_irq`=1. Write 0x10=0 -> `soft_irq`=0. Access 0x18, 0x02, or a write to 0x14 -> `bus_err`=1 with `bus_ready` and no register change.
- Reset mid-operation: assert `reset` with `timer_irq`=1 and a read in flight -> all outputs 0, no `bus_ready`, `mtimecmp` reads all-ones afterward.
